// File: rtl/fp_acc_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp_acc_seq
// Description : Sequential float32 stream accumulator. Feeds an external
//               float32 adder with (running sum, sample), captures its
//               result after ADD_LAT cycles and emits the stream total and
//               sample count on a valid/ready output port.
//               Optional macro FP_ACC_SEQ_FTZ_EN flushes denormal samples to
//               signed zero before they reach the adder.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_acc_seq #(
    parameter int ADD_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

    // Wait counter must be able to hold ADD_LAT; keep at least one bit.
    localparam int WCNT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        add_a_q, add_a_d;
    logic [31:0]        add_b_q, add_b_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               last_q, last_d;
    logic [31:0]        sample_w;

`ifdef FP_ACC_SEQ_FTZ_EN
    // The adder cannot handle denormals: zero exponent becomes signed zero.
    assign sample_w = (in_data[30:23] == 8'h00) ? {in_data[31], 31'h0} : in_data;
`else
    assign sample_w = in_data;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= 32'h0;
            add_a_q     <= 32'h0;
            add_b_q     <= 32'h0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_count_q <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            last_q      <= last_d;
        end
    end

    // Next-state logic: accept sample, wait out adder latency, emit total.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        last_d      = last_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    add_a_d = acc_q;
                    add_b_d = sample_w;
                    last_d  = in_last;
                    // Count saturates; accumulation carries on regardless.
                    cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                    wcnt_d  = WCNT_W'(ADD_LAT);
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else begin
                    acc_d = add_res;
                    if (last_q) begin
                        out_data_d  = add_res;
                        out_count_d = cnt_q;
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = 32'h0;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_acc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_acc_seq
// Description : Self-checking bench for fp_acc_seq. Instance 0 uses a
//               combinational adder model (ADD_LAT=0, CNT_W=2), instance 1 a
//               3-cycle delayed adder model (ADD_LAT=3, CNT_W=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_acc_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld  [2];
    logic        rdy  [2];
    logic [31:0] dat  [2];
    logic        lst  [2];
    logic [31:0] aa   [2];
    logic [31:0] ab   [2];
    logic [31:0] ares [2];
    logic        ov   [2];
    logic        ordy [2];
    logic [31:0] od   [2];
    logic [1:0]  oc0;
    logic [15:0] oc1;
    logic [31:0] pipe [3];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] acc_m [2];
    logic [15:0] cnt_m [2];
    logic [47:0] sb [$];

    always #5 clk = ~clk;

    // Simple float32 adder for positive operands (truncating), denormal aware.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        int          ex, ey, d;
        logic [24:0] mx, my, s;
        if (a[30:0] == 31'h0) return b;
        if (b[30:0] == 31'h0) return a;
        if (a[30:23] >= b[30:23]) begin x = a; y = b; end else begin x = b; y = a; end
        ex = (x[30:23] == 8'h0) ? 1 : int'(x[30:23]);
        ey = (y[30:23] == 8'h0) ? 1 : int'(y[30:23]);
        mx = {1'b0, x[30:23] != 8'h0, x[22:0]};
        my = {1'b0, y[30:23] != 8'h0, y[22:0]};
        d  = ex - ey;
        my = (d > 24) ? 25'h0 : (my >> d);
        s  = mx + my;
        if (s[24]) begin s = s >> 1; ex = ex + 1; end
        while (!s[23] && ex > 1) begin s = s << 1; ex = ex - 1; end
        if (!s[23]) ex = 0;
        return {1'b0, ex[7:0], s[22:0]};
    endfunction

    function automatic logic [31:0] filt(input logic [31:0] d);
`ifdef FP_ACC_SEQ_FTZ_EN
        return (d[30:23] == 8'h0) ? {d[31], 31'h0} : d;
`else
        return d;
`endif
    endfunction

    // Combinational golden adder for instance 0.
    always_comb ares[0] = fadd(aa[0], ab[0]);

    // Three-stage delayed adder for instance 1.
    always @(posedge clk) begin
        pipe[0] <= fadd(aa[1], ab[1]);
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    always_comb ares[1] = pipe[2];

    fp_acc_seq #(.ADD_LAT(0), .CNT_W(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(dat[0]), .in_last(lst[0]),
        .add_a(aa[0]), .add_b(ab[0]), .add_res(ares[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_count(oc0)
    );

    fp_acc_seq #(.ADD_LAT(3), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(dat[1]), .in_last(lst[1]),
        .add_a(aa[1]), .add_b(ab[1]), .add_res(ares[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_count(oc1)
    );

    function automatic logic [15:0] ocnt(input int k);
        return (k == 0) ? {14'h0, oc0} : oc1;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one sample on instance k and check occupancy cycle by cycle.
    task automatic send(input int k, input logic [31:0] d, input logic last);
        int          lat;
        logic [31:0] fb, ea;
        bit          got;
        lat = (k == 0) ? 0 : 3;
        fb  = filt(d);
        ea  = acc_m[k];
        vld[k] = 1'b1; dat[k] = d; lst[k] = last;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rdy[k]) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("accept_wait", {47'h0, got}, 48'h1);
        @(negedge clk);
        vld[k] = 1'b0; lst[k] = 1'b0;
        acc_m[k] = fadd(acc_m[k], fb);
        if (cnt_m[k] != ((k == 0) ? 16'h3 : 16'hFFFF)) cnt_m[k] = cnt_m[k] + 16'h1;
        for (int i = 1; i <= lat + 1; i++) begin
            if (i > 1) @(negedge clk);
            chk("busy_in_ready", {47'h0, rdy[k]}, 48'h0);
            chk("busy_out_valid", {47'h0, ov[k]}, 48'h0);
            chk("add_a", {16'h0, aa[k]}, {16'h0, ea});
            chk("add_b", {16'h0, ab[k]}, {16'h0, fb});
        end
        @(negedge clk);
        if (last) begin
            chk("out_valid_rise", {46'h0, ov[k], rdy[k]}, 48'h2);
            sb.push_back({acc_m[k], cnt_m[k]});
        end else begin
            chk("ready_return", {46'h0, ov[k], rdy[k]}, 48'h1);
        end
    endtask

    // Pop the expected total, optionally stall, then complete the handshake.
    task automatic take(input int k, input int hold);
        logic [47:0] e;
        chk("sb_nonempty", {47'h0, sb.size() != 0}, 48'h1);
        e = (sb.size() != 0) ? sb.pop_front() : 48'h0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_flags", {46'h0, ov[k], rdy[k]}, 48'h2);
            chk("hold_total", {od[k], ocnt(k)}, e);
        end
        ordy[k] = 1'b1;
        chk("total", {od[k], ocnt(k)}, e);
        @(negedge clk);
        ordy[k] = 1'b0;
        chk("post_handshake", {46'h0, ov[k], rdy[k]}, 48'h1);
        acc_m[k] = 32'h0;
        cnt_m[k] = 16'h0;
    endtask

    task automatic chk_reset(input int k);
        chk("rst_flags", {46'h0, ov[k], rdy[k]}, 48'h1);
        chk("rst_add", {aa[k], ab[k][15:0]}, 48'h0);
        chk("rst_out", {od[k], ocnt(k)}, 48'h0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0; dat[k] = 32'h0; lst[k] = 1'b0; ordy[k] = 1'b0;
            acc_m[k] = 32'h0; cnt_m[k] = 16'h0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset(0);
        chk_reset(1);

        // Two-sample stream, combinational adder, then 5-cycle backpressure.
        send(0, 32'h3F800000, 1'b0);
        send(0, 32'h40000000, 1'b1);
        take(0, 5);
        // Accumulator cleared: single-sample stream.
        send(0, 32'h3F000000, 1'b1);
        take(0, 0);

        // Delayed adder: 1.5 + 1.5.
        send(1, 32'h3FC00000, 1'b0);
        send(1, 32'h3FC00000, 1'b1);
        take(1, 0);

        // Counter saturation at 3 with CNT_W=2; sum keeps growing.
        for (int i = 0; i < 5; i++) send(0, 32'h3F800000, i == 4);
        take(0, 2);

        // Reset in the middle of a stream.
        send(0, 32'h3F800000, 1'b0);
        send(0, 32'h3F800000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset(0);
        chk_reset(1);
        acc_m[0] = 32'h0; cnt_m[0] = 16'h0;
        send(0, 32'h3FC00000, 1'b0);
        send(0, 32'h3FC00000, 1'b1);
        take(0, 0);

        // Denormal sample followed by 1.0.
        send(1, 32'h00000001, 1'b0);
        send(1, 32'h3F800000, 1'b1);
        take(1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fp_acc_seq.md
Name: fp_acc_seq

Overview:
- Sequential accumulation controller that wraps the team's combinational float32 adder (operands a, b, result res).
- Accepts a valid/ready stream of IEEE-754 single-precision samples, each terminated by a last flag.
- Drives the adder with running sum + sample, captures the adder result, and emits the stream total plus sample count on a valid/ready output port.
- Sits directly upstream and downstream of the adder: feeds its a/b, consumes its res.

Parameters:
- ADD_LAT, 0, adder pipeline latency in cycles (0 = combinational adder).
- CNT_W, 16, width of sample counter and out_count.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_data  in  32  float32 sample.
- in_last  in  1  sample is last of stream.
- add_a  out  32  adder operand a (running sum).
- add_b  out  32  adder operand b (sample).
- add_res  in  32  adder result.
- out_valid  out  1  stream total available.
- out_ready  in  1  consumer accepts total.
- out_data  out  32  float32 stream total.
- out_count  out  CNT_W  samples in stream.

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state is updated on the rising edge of clk.
- in_ready is combinational: in_ready = (state == S_IDLE). All other outputs are registered.
- Reset values: state S_IDLE, acc 32'h0, add_a 0, add_b 0, out_valid 0, out_data 0, out_count 0, cnt 0, wcnt 0, last_q 0.
- S_IDLE, on in_valid && in_ready:
  - add_a <= acc; add_b <= in_data (FTZ-filtered, see Optional Feature); last_q <= in_last.
  - cnt <= cnt+1, saturating at all-ones.
  - wcnt <= ADD_LAT; go to S_ADD.
- S_IDLE, no handshake: hold state.
- S_ADD, wcnt != 0: wcnt <= wcnt-1.
- S_ADD, wcnt == 0:
  - acc <= add_res.
  - If last_q: out_data <= add_res, out_count <= cnt (including this sample), out_valid <= 1; go to S_OUT.
  - Otherwise go to S_IDLE.
- S_OUT: out_valid, out_data and out_count held stable until out_ready. On out_valid && out_ready: out_valid <= 0, acc <= 0, cnt <= 0; go to S_IDLE.
- add_a/add_b stay stable for the whole of S_ADD. Outside S_ADD they keep their last values.
- Latency and throughput:
  - Per-sample occupancy is ADD_LAT+2 cycles (accept cycle + ADD_LAT+1 cycles in S_ADD).
  - in_ready is low for exactly ADD_LAT+1 cycles after each accept.
  - out_valid rises on the edge ADD_LAT+1 cycles after the edge accepting the last sample.
- Single-sample stream (in_last on first sample): out_data = adder(+0, sample), out_count = 1.
- Arithmetic: this block performs no float arithmetic; all sums come from add_res. The initial accumulator is +0 (32'h0).
- Counter: cnt saturates at 2^CNT_W-1 and never wraps. Accumulation continues while saturated.
- in_valid without a handshake (state not S_IDLE): sample ignored; upstream must hold it.
- out_ready in any state other than S_OUT: ignored.
- Reset mid-operation, any state: the partial sum is discarded. The cycle after rst, all registers hold reset values, out_valid is 0 and in_ready is 1.
- rst has priority over any simultaneous handshake.

Optional Feature:
- Macro: FP_ACC_SEQ_FTZ_EN.
- Defined: a sample with exponent field in_data[30:23] == 0 is issued as {in_data[31], 31'h0}, i.e. denormals flushed to signed zero before add_b. The adder does not handle denormals.
- Undefined: in_data is passed to add_b unmodified.

Test Plan:
- ADD_LAT=0, combinational golden adder: stream 3F800000, 40000000(last) -> out_data 40400000, out_count 2; out_valid high 1 edge after the last accept; in_ready low exactly 1 cycle per accept.
- Backpressure: after total ready, hold out_ready=0 for 5 cycles -> out_valid=1, out_data/out_count stable, in_ready=0 throughout. Then handshake and send single 3F000000(last) -> out_data 3F000000, out_count 1 (accumulator cleared).
- ADD_LAT=3, adder model delayed 3 cycles: stream 3FC00000, 3FC00000(last) -> in_ready low exactly 4 cycles after each accept; out_data 40400000, out_count 2.
- Reset mid-stream: assert rst for 1 cycle after 2 of 4 samples (3F800000 each) accepted -> out_valid 0, in_ready 1 next cycle. New stream 3FC00000, 3FC00000(last) -> 40400000, count 2.
- FTZ: stream 00000001, 3F800000(last).
  - With FP_ACC_SEQ_FTZ_EN: add_b = 00000000 on the first sample; out_data 3F800000.
  - Without it: add_b = 00000001 on the first sample.
- Saturation, CNT_W=2: five samples of 3F800000, last on the fifth -> out_count 3, out_data 40A00000.
